// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM dimming, leading-zero blanking and tear-free buffer updates.
// Latency: seg/dp/an are registered one clk after the slot, brightness, blanking or buffer change that drives them.
// Backpressure: none; load is a fire-and-forget strobe and the pending buffer simply holds the most recent capture.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   digits_in       hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in           decimal-point request per digit
//   load            one-cycle strobe capturing digits_in/dp_in into the pending buffer
//   blank_lz        leading-zero blanking enable
//   brightness      PWM duty (0 = dark)
//   seg, dp, an     registered segment, decimal point and digit-enable drives (polarity per ACTIVE_LOW)
//   frame_tick      high in the cycle the slot index wraps from the last digit back to digit 0
// Optional feature macro: SSD_BLINK_EN adds blink_mask and a blink phase toggling every 64 frames.

module ssd_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BRIGHT_BITS    = 4,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [BRIGHT_BITS-1:0]    brightness,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int SW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(REFRESH_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(REFRESH_CYCLES - 1);
    localparam logic          POL       = (ACTIVE_LOW != 0);

    // Inactive output levels, also the reset values.
    localparam logic [6:0]            SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

    logic [SW-1:0]           slot_q, slot_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [BRIGHT_BITS-1:0]  pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tmr_wrap;
    logic                    frame_wrap;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   zero_from;   // bit i: digits i..NUM_DIGITS-1 are all zero
    logic                    blank;
    logic                    dark;
    logic [6:0]              seg_on;
    logic                    dp_on;
    logic [NUM_DIGITS-1:0]   an_on;

    // Active-high glyphs {g,f,e,d,c,b,a}; b and d are the lowercase forms.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    hex_glyph = 7'b0111111;
            4'h1:    hex_glyph = 7'b0000110;
            4'h2:    hex_glyph = 7'b1011011;
            4'h3:    hex_glyph = 7'b1001111;
            4'h4:    hex_glyph = 7'b1100110;
            4'h5:    hex_glyph = 7'b1101101;
            4'h6:    hex_glyph = 7'b1111101;
            4'h7:    hex_glyph = 7'b0000111;
            4'h8:    hex_glyph = 7'b1111111;
            4'h9:    hex_glyph = 7'b1101111;
            4'hA:    hex_glyph = 7'b1110111;
            4'hB:    hex_glyph = 7'b1111100;
            4'hC:    hex_glyph = 7'b0111001;
            4'hD:    hex_glyph = 7'b1011110;
            4'hE:    hex_glyph = 7'b1111001;
            default: hex_glyph = 7'b1110001;
        endcase
    endfunction

`ifdef SSD_BLINK_EN
    logic [5:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_wrap) begin
            blink_cnt_d = blink_cnt_q + 6'd1;
            // Phase flips on every 64th frame wrap.
            if (blink_cnt_q == 6'd63) begin
                blink_ph_d = ~blink_ph_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign dark = blink_ph_q & blink_mask[slot_q];
`else
    assign dark = 1'b0;
`endif

    // Scan timing and buffers.
    always_comb begin
        tmr_wrap   = (tmr_q == TMR_LAST);
        frame_wrap = tmr_wrap && (slot_q == SLOT_LAST);

        tmr_d  = tmr_wrap ? '0 : tmr_q + 1'b1;
        slot_d = slot_q;
        if (tmr_wrap) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;

        pend_dig_d = load ? digits_in : pend_dig_q;
        pend_dp_d  = load ? dp_in     : pend_dp_q;

        // Taking the transfer from the pending next-state lets a load that
        // coincides with the frame wrap go straight to the active buffer.
        act_dig_d = frame_wrap ? pend_dig_d : act_dig_q;
        act_dp_d  = frame_wrap ? pend_dp_d  : act_dp_q;
    end

    // Decode of the currently scanned digit.
    always_comb begin
        logic acc;
        nib = act_dig_q[{slot_q, 2'b00} +: 4];

        acc       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (act_dig_q[4*i +: 4] == 4'h0);
            zero_from[i] = acc;
        end
        blank = blank_lz && (slot_q != '0) && zero_from[slot_q];

        seg_on = blank ? 7'b0000000 : hex_glyph(nib);
        dp_on  = act_dp_q[slot_q];

        an_on         = '0;
        an_on[slot_q] = (pwm_q < brightness);

        if (dark) begin
            seg_on = '0;
            dp_on  = 1'b0;
            an_on  = '0;
        end

        seg_d = seg_on ^ SEG_OFF;
        dp_d  = dp_on  ^ POL;
        an_d  = an_on  ^ AN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            tmr_q      <= '0;
            pwm_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= POL;
            an_q       <= AN_OFF;
        end else begin
            slot_q     <= slot_d;
            tmr_q      <= tmr_d;
            pwm_q      <= pwm_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_wrap;

endmodule
